// File: rtl/pipe_unpack_pkg.sv
// Shared constants and helpers for the pipe word stream blocks.
// Default widths, the clog2 constant function and the slice-order default
// (selected by the PIPE_UNPACK_MSB_FIRST_EN macro) live here.
package pipe_unpack_pkg;

    localparam int PIPE_W_DATA = 32;
    localparam int PIPE_W_OUT  = 8;

`ifdef PIPE_UNPACK_MSB_FIRST_EN
    localparam bit PIPE_SLICE_MSB_FIRST = 1'b1;
`else
    localparam bit PIPE_SLICE_MSB_FIRST = 1'b0;
`endif

    // Ceiling log2 of a positive constant (clog2(1) == 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Ceiling log2 but never narrower than one bit, for counter/pointer widths.
    function automatic int clog2_min1(input int value);
        int result;
        result = clog2(value);
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Synchronous DEPTH x WIDTH FIFO shared by both sides of the pipe.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// the head entry is presented combinationally. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module pipe_fifo
    import pipe_unpack_pkg::*;
#(
    parameter int WIDTH = PIPE_W_DATA + 1,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = clog2_min1(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_s;
    logic             empty_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop && !empty_s;
    assign push_ok_s = push && (!full_s || pop_ok_s);

    assign full  = full_s;
    assign empty = empty_s;
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

    // Advance the read and write pointers on accepted pop/push.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage: write the pushed word at the write pointer; cleared on reset.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
            end else begin
                mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/pipe_unpack.sv
// Receive side of the pipe word stream: buffers W_DATA-wide words and emits
// each as RATIO = W_DATA/W_OUT narrow slices on a valid/ready port.
// Optional macro PIPE_UNPACK_MSB_FIRST_EN: emit the most significant slice
// first instead of the default least significant slice first.
module pipe_unpack
    import pipe_unpack_pkg::*;
#(
    parameter int W_DATA = PIPE_W_DATA,
    parameter int W_OUT  = PIPE_W_OUT,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              resetn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_DATA-1:0] i_data,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W_OUT-1:0]  o_data,
    output logic              o_last,
    output logic              o_busy
);

    localparam int RATIO = W_DATA / W_OUT;
    localparam int CW    = clog2_min1(RATIO);
    localparam int NSLOT = 2 ** CW;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [W_DATA:0]   head_s;
    logic [CW-1:0]     cnt_r;
    logic              ready_en_r;
    logic              last_slice_s;
    logic              xfer_s;
    logic              pop_s;
    logic              push_s;
    logic [W_OUT-1:0]  slices_s [NSLOT];

    // Handshake glue: a slice moves only when something is buffered.
    assign last_slice_s = (cnt_r == LAST_IDX);
    assign xfer_s       = !fifo_empty_s && i_ready;
    assign pop_s        = xfer_s && last_slice_s;
    assign o_ready      = ready_en_r && (!fifo_full_s || pop_s);
    assign push_s       = i_valid && o_ready;

    pipe_fifo #(
        .WIDTH (W_DATA + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .resetn  (resetn),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data ({i_last, i_data}),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .head    (head_s)
    );

    // Slice table of the head word; unused slots (non power-of-two RATIO) read zero.
    for (genvar k = 0; k < NSLOT; k++) begin : g_slice
        if (k < RATIO) begin : g_used
`ifdef PIPE_UNPACK_MSB_FIRST_EN
            assign slices_s[k] = head_s[W_DATA-1-k*W_OUT -: W_OUT];
`else
            assign slices_s[k] = head_s[k*W_OUT +: W_OUT];
`endif
        end else begin : g_unused
            assign slices_s[k] = {W_OUT{1'b0}};
        end
    end

    // Accept words only from the first clock edge after reset is released.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Slice counter: advance per transfer, wrap (and pop) after the last slice.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            if (xfer_s) begin
                if (last_slice_s) begin
                    cnt_r <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Output mux: present the current slice of the head word while non-empty.
    always_comb begin
        o_valid = 1'b0;
        o_data  = {W_OUT{1'b0}};
        o_last  = 1'b0;
        o_busy  = 1'b0;
        if (!fifo_empty_s) begin
            o_valid = 1'b1;
            o_data  = slices_s[cnt_r];
            o_last  = head_s[W_DATA] && last_slice_s;
            o_busy  = 1'b1;
        end else begin
            o_valid = 1'b0;
            o_data  = {W_OUT{1'b0}};
            o_last  = 1'b0;
            o_busy  = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_unpack.sv
// Scoreboard bench for pipe_unpack: accepted words push their expected slices
// into a queue; a monitor pops and compares on every slice transfer.
module tb_pipe_unpack;

    logic        i_clk;
    logic        resetn;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        i_last;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_last;
    logic        o_busy;

    int passed = 0;
    int total  = 0;
    logic [8:0] exp_q [$];

    pipe_unpack #(.W_DATA(32), .W_OUT(8), .DEPTH(2)) dut (
        .i_clk   (i_clk),
        .resetn  (resetn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] slice_of(input logic [31:0] w, input int k);
        logic [31:0] t;
        t = w;
`ifdef PIPE_UNPACK_MSB_FIRST_EN
        return t[31-8*k -: 8];
`else
        return t[8*k +: 8];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w, input logic last);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({(last && (k == 3)), slice_of(w, k)});
    endtask

    // Drive one word until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] w, input logic last);
        logic acc;
        acc = 1'b0;
        i_valid = 1'b1;
        i_data  = w;
        i_last  = last;
        for (int n = 0; n < 60 && !acc; n++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        if (acc) push_exp(w, last);
        check("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
        check(name, exp_q.size(), 32'd0);
        step();
        check({name, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({name, "_valid"}, {31'd0, o_valid}, 32'd0);
    endtask

    // Monitor: compare every transferred slice with the scoreboard head.
    always @(negedge i_clk) begin
        if (resetn && o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_slice: got %h last %b, expected none", o_data, o_last);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({o_last, o_data} === e) passed++;
                else $display("FAIL slice: got data %h last %b, expected data %h last %b",
                              o_data, o_last, e[7:0], e[8]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        i_valid = 1'b0;
        i_data  = 32'd0;
        i_last  = 1'b0;
        i_ready = 1'b0;

        // Reset state
        #12;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data",  {24'd0, o_data},  32'd0);
        check("rst_last",  {31'd0, o_last},  32'd0);
        check("rst_busy",  {31'd0, o_busy},  32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        #10;
        resetn = 1'b1;
        step();
        check("ready_after_rst", {31'd0, o_ready}, 32'd1);

        // Single word, no same-cycle bypass, 4 slices then busy drops
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hA1B2C3D4;
        i_last  = 1'b1;
        #3;
        check("no_bypass", {31'd0, o_valid}, 32'd0);
        send(32'hA1B2C3D4, 1'b1);
        check("latency_valid", {31'd0, o_valid}, 32'd1);
        check("first_slice", {24'd0, o_data}, {24'd0, slice_of(32'hA1B2C3D4, 0)});
        step();
        step();
        step();
        check("busy_mid", {31'd0, o_busy}, 32'd1);
        step();
        check("busy_drop", {31'd0, o_busy}, 32'd0);
        check("single_drained", exp_q.size(), 32'd0);

        // Back-to-back words: 8 contiguous slices, o_ready low while full
        send(32'h11223344, 1'b0);
        send(32'h55667788, 1'b1);
        for (int i = 1; i < 8; i++) begin
            check("b2b_valid", {31'd0, o_valid}, 32'd1);
            check("b2b_ready", {31'd0, o_ready}, (i == 1 || i == 2) ? 32'd0 : 32'd1);
            step();
        end
        check("b2b_drained", exp_q.size(), 32'd0);
        check("b2b_end_valid", {31'd0, o_valid}, 32'd0);

        // Stall at slice 2 for 5 cycles while the FIFO fills
        send(32'hA1B2C3D4, 1'b0);
        step();
        step();
        i_ready = 1'b0;
        check("stall_slice", {24'd0, o_data}, {24'd0, slice_of(32'hA1B2C3D4, 2)});
        send(32'h01020304, 1'b0);
        i_valid = 1'b1;
        i_data  = 32'h05060708;
        i_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stall_ready", {31'd0, o_ready}, 32'd0);
            check("stall_valid", {31'd0, o_valid}, 32'd1);
            check("stall_hold", {24'd0, o_data}, {24'd0, slice_of(32'hA1B2C3D4, 2)});
            step();
        end
        // Full FIFO: push accepted only on the final-slice pop
        i_ready = 1'b1;
        send(32'h05060708, 1'b1);
        check("full_after_swap", {31'd0, o_ready}, 32'd0);
        check("swap_head", {24'd0, o_data}, {24'd0, slice_of(32'h01020304, 0)});
        wait_drain("stall_drain");

        // Reset mid-word, then a fresh word
        send(32'hCAFEBABE, 1'b1);
        step();
        resetn = 1'b0;
        #1;
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_busy",  {31'd0, o_busy},  32'd0);
        check("arst_data",  {24'd0, o_data},  32'd0);
        exp_q.delete();
        #2;
        resetn = 1'b1;
        step();
        check("arst_ready", {31'd0, o_ready}, 32'd1);
        send(32'h00000001, 1'b1);
        check("post_rst_slice0", {24'd0, o_data}, {24'd0, slice_of(32'h00000001, 0)});
        wait_drain("post_rst_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
